// File: rtl/dma_ram_pkg.sv
// ============================================================================
// Module   : dma_ram_pkg
// Purpose  : Shared constants, typedefs and the grant encoding used by the
//            DMA RAM arbiter and its response FIFO.
// Contents : AXI_WIDTH, AXI_ADDR_WIDTH, LSB, word_t, waddr_t, strb_t, grant_e
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dma_ram_pkg;

  localparam int AXI_WIDTH      = 128;
  localparam int AXI_ADDR_WIDTH = 32;
  // Byte-to-word address shift for one AXI_WIDTH data word.
  localparam int LSB            = $clog2(AXI_WIDTH) - 3;

  typedef logic [AXI_WIDTH-1:0]          word_t;
  typedef logic [AXI_ADDR_WIDTH-LSB-1:0] waddr_t;
  typedef logic [AXI_WIDTH/8-1:0]        strb_t;

  // Identifies which requester owned the most recent RAM grant.
  typedef enum logic {
    GR_RD = 1'b0,
    GR_WR = 1'b1
  } grant_e;

endpackage : dma_ram_pkg

`default_nettype wire

// File: rtl/dma_resp_fifo.sv
// ============================================================================
// Module   : dma_resp_fifo
// Purpose  : Synchronous read-response FIFO with registered head data and
//            head valid. Arbitrary DEPTH (>= 2, need not be a power of two).
// Ports    : clk, rst            - clock, synchronous active-high reset
//            push_i, data_i      - write one entry
//            pop_i               - remove head entry (ignored when empty)
//            data_o, valid_o     - registered head entry / non-empty flag
//            count_o             - current occupancy
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_resp_fifo
  import dma_ram_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int WIDTH = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] C_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d, count_mid;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q;
  logic             do_pop;

  always_comb begin
    do_pop   = pop_i && valid_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == C_LAST) ? '0 : rd_ptr_q + PW'(1);
    end
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == C_LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    count_mid = count_q - CW'(do_pop);
    count_d   = count_mid + CW'(push_i);
    // The next head is either an entry already stored, or the word being
    // pushed right now when nothing else remains after the pop.
    if (count_mid == '0) begin
      head_d = data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      head_q   <= head_d;
    end
  end

  assign data_o  = head_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

  // Upstream credit accounting must never let a push land on a full FIFO.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push_i && !do_pop && (count_q == C_FULL)));

endmodule : dma_resp_fifo

`default_nettype wire

// File: rtl/dma_ram_arbiter.sv
// ============================================================================
// Module   : dma_ram_arbiter
// Purpose  : Round-robin arbiter sharing one single-port RAM (1-cycle read
//            latency) between the MM2S read engine and the S2MM write engine.
//            Read data is buffered in a response FIFO; reads are only granted
//            while a FIFO slot is guaranteed (credit = count + inflight).
// Ports    : clk, rst                             - clock, sync reset
//            rd_req_valid/ready/addr              - read request channel
//            rd_resp_valid/ready/data             - read response channel
//            wr_req_valid/ready/addr/data/strb    - write request channel
//            mem_ren/wen/addr/wdata/strb, mem_rdata - RAM port
//            rd_count, wr_count                   - accepted transfer counters
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_ram_arbiter
  import dma_ram_pkg::*;
#(
  parameter int AXI_WIDTH      = dma_ram_pkg::AXI_WIDTH,
  parameter int AXI_ADDR_WIDTH = dma_ram_pkg::AXI_ADDR_WIDTH,
  parameter int RESP_DEPTH     = 3
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        rd_req_valid,
  output logic                                        rd_req_ready,
  input  logic [AXI_ADDR_WIDTH-($clog2(AXI_WIDTH)-3)-1:0] rd_req_addr,
  output logic                                        rd_resp_valid,
  input  logic                                        rd_resp_ready,
  output logic [AXI_WIDTH-1:0]                        rd_resp_data,
  input  logic                                        wr_req_valid,
  output logic                                        wr_req_ready,
  input  logic [AXI_ADDR_WIDTH-($clog2(AXI_WIDTH)-3)-1:0] wr_req_addr,
  input  logic [AXI_WIDTH-1:0]                        wr_req_data,
  input  logic [AXI_WIDTH/8-1:0]                      wr_req_strb,
  output logic                                        mem_ren,
  output logic                                        mem_wen,
  output logic [AXI_ADDR_WIDTH-($clog2(AXI_WIDTH)-3)-1:0] mem_addr,
  output logic [AXI_WIDTH-1:0]                        mem_wdata,
  output logic [AXI_WIDTH/8-1:0]                      mem_strb,
  input  logic [AXI_WIDTH-1:0]                        mem_rdata,
  output logic [31:0]                                 rd_count,
  output logic [31:0]                                 wr_count
);

  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [CW:0] C_DEPTH = (CW + 1)'(RESP_DEPTH);

  grant_e                 last_grant_q, last_grant_d;
  logic                   inflight_q;
  logic [31:0]            rd_count_q, rd_count_d;
  logic [31:0]            wr_count_q, wr_count_d;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_valid;
  logic [AXI_WIDTH-1:0]   fifo_data;
  logic [CW:0]            occupancy;
  logic                   rd_elig, wr_elig;
  logic                   grant_rd, grant_wr;
  logic                   resp_pop;

  always_comb begin
    // Slots already claimed: buffered words plus the read currently in the
    // RAM pipeline. A same-cycle pop is deliberately not credited so that
    // rd_req_ready never depends combinationally on rd_resp_ready.
    occupancy    = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    rd_elig      = rd_req_valid && (occupancy < C_DEPTH);
    wr_elig      = wr_req_valid;
    grant_rd     = 1'b0;
    grant_wr     = 1'b0;
    last_grant_d = last_grant_q;
    rd_count_d   = rd_count_q;
    wr_count_d   = wr_count_q;
    if (!rst) begin
      if (rd_elig && wr_elig) begin
        if (last_grant_q == GR_WR) begin
          grant_rd = 1'b1;
        end else begin
          grant_wr = 1'b1;
        end
      end else if (rd_elig) begin
        grant_rd = 1'b1;
      end else if (wr_elig) begin
        grant_wr = 1'b1;
      end
    end
    if (grant_rd) begin
      last_grant_d = GR_RD;
      rd_count_d   = rd_count_q + 32'd1;
    end else if (grant_wr) begin
      last_grant_d = GR_WR;
      wr_count_d   = wr_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GR_WR;
      inflight_q   <= 1'b0;
      rd_count_q   <= '0;
      wr_count_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      inflight_q   <= grant_rd;
      rd_count_q   <= rd_count_d;
      wr_count_q   <= wr_count_d;
    end
  end

  // mem_rdata is valid exactly in the cycle after a read grant, which is
  // when inflight_q is set, so inflight_q doubles as the FIFO push.
  dma_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (AXI_WIDTH)
  ) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .data_i  (mem_rdata),
    .pop_i   (resp_pop),
    .data_o  (fifo_data),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign rd_resp_valid = fifo_valid && !rst;
  assign resp_pop      = rd_resp_valid && rd_resp_ready;
  assign rd_resp_data  = fifo_data;

  assign rd_req_ready  = grant_rd;
  assign wr_req_ready  = grant_wr;
  assign mem_ren       = grant_rd;
  assign mem_wen       = grant_wr;
  assign mem_addr      = grant_wr ? wr_req_addr : rd_req_addr;
  assign mem_wdata     = wr_req_data;
  assign mem_strb      = wr_req_strb;

  assign rd_count      = rd_count_q;
  assign wr_count      = wr_count_q;

endmodule : dma_ram_arbiter

`default_nettype wire

// File: tb/tb_dma_ram_arbiter.sv
// ============================================================================
// Module   : tb_dma_ram_arbiter
// Purpose  : Self-checking bench for dma_ram_arbiter with a byte-strobed
//            1-cycle-latency RAM model and a read-response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_ram_arbiter;
  import dma_ram_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req_valid, rd_req_ready;
  waddr_t      rd_req_addr;
  logic        rd_resp_valid, rd_resp_ready;
  word_t       rd_resp_data;
  logic        wr_req_valid, wr_req_ready;
  waddr_t      wr_req_addr;
  word_t       wr_req_data;
  strb_t       wr_req_strb;
  logic        mem_ren, mem_wen;
  waddr_t      mem_addr;
  word_t       mem_wdata;
  strb_t       mem_strb;
  word_t       mem_rdata;
  logic [31:0] rd_count, wr_count;

  int    errors = 0;
  int    checks = 0;
  word_t exp_q[$];
  logic  ram_init = 1'b1;
  word_t ram [64];

  always #5 clk = ~clk;

  dma_ram_arbiter #(
    .AXI_WIDTH      (128),
    .AXI_ADDR_WIDTH (32),
    .RESP_DEPTH     (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_req_addr   (rd_req_addr),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_ready (rd_resp_ready),
    .rd_resp_data  (rd_resp_data),
    .wr_req_valid  (wr_req_valid),
    .wr_req_ready  (wr_req_ready),
    .wr_req_addr   (wr_req_addr),
    .wr_req_data   (wr_req_data),
    .wr_req_strb   (wr_req_strb),
    .mem_ren       (mem_ren),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_strb      (mem_strb),
    .mem_rdata     (mem_rdata),
    .rd_count      (rd_count),
    .wr_count      (wr_count)
  );

  // Initial RAM contents: every 32-bit lane holds 0xA5A5A5nn, nn = word index.
  function automatic word_t pat(input int a);
    logic [31:0] w;
    w = 32'hA5A5_A500 + {24'h0, a[7:0]};
    return {4{w}};
  endfunction

  // Byte-wise RAM model, read data one cycle after mem_ren.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= pat(i);
    end else begin
      if (mem_wen) begin
        for (int b = 0; b < 16; b++) begin
          if (mem_strb[b]) ram[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end
      if (mem_ren) mem_rdata <= ram[mem_addr[5:0]];
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every accepted response must match the queue head.
  always @(negedge clk) begin
    if (rd_resp_valid && rd_resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", rd_resp_data, '0);
        if (rd_resp_data === '0) begin
          errors++;
          $display("FAIL unexpected_resp: got response with none expected");
        end
      end else begin
        chk("rd_data", rd_resp_data, exp_q.pop_front());
      end
    end
  end

  // The two RAM enables must never be high together.
  always @(negedge clk) begin
    if (!rst && (mem_ren || mem_wen)) chk("mem_excl", {127'h0, mem_ren && mem_wen}, '0);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic e_rdy;
    int   nxt;

    rst = 1'b1;
    rd_req_valid = 1'b1; rd_req_addr = '0;
    wr_req_valid = 1'b1; wr_req_addr = '0;
    wr_req_data = '0; wr_req_strb = '0;
    rd_resp_ready = 1'b1;

    // Reset with both valids high: nothing granted, counters zero.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      ram_init = 1'b0;
      chk("rst_mem_ren", mem_ren, 0);
      chk("rst_mem_wen", mem_wen, 0);
      chk("rst_rd_ready", rd_req_ready, 0);
      chk("rst_wr_ready", wr_req_ready, 0);
      chk("rst_resp_valid", rd_resp_valid, 0);
      chk("rst_rd_count", rd_count, 0);
      chk("rst_wr_count", wr_count, 0);
      next_cycle();
    end
    rst = 1'b0;
    idle(1);

    // Write 0x10 then read it back; response two cycles after the read grant.
    wr_req_valid = 1'b1; wr_req_addr = waddr_t'(28'h10);
    wr_req_data  = 128'h01234567_89ABCDEF_00000000_DEADBEEF;
    wr_req_strb  = 16'hFFFF;
    @(negedge clk);
    chk("wtr_wr_ready", wr_req_ready, 1);
    chk("wtr_mem_wen", mem_wen, 1);
    next_cycle();
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b1; rd_req_addr = waddr_t'(28'h10);
    @(negedge clk);
    chk("wtr_rd_ready", rd_req_ready, 1);
    chk("wtr_mem_addr", mem_addr, 28'h10);
    exp_q.push_back(128'h01234567_89ABCDEF_00000000_DEADBEEF);
    next_cycle();
    rd_req_valid = 1'b0;
    @(negedge clk);
    chk("wtr_resp_early", rd_resp_valid, 0);
    chk("wtr_rd_count", rd_count, 1);
    chk("wtr_wr_count", wr_count, 1);
    next_cycle();
    @(negedge clk);
    chk("wtr_resp_valid", rd_resp_valid, 1);
    next_cycle();
    idle(3);

    // Contention after reset: strict RD,WR,RD,WR alternation.
    do_reset(1);
    rd_req_addr = waddr_t'(28'h20);
    wr_req_addr = waddr_t'(28'h21);
    wr_req_data = 128'h0;
    wr_req_strb = 16'hFFFF;
    for (int c = 0; c < 8; c++) begin
      rd_req_valid = 1'b1; wr_req_valid = 1'b1;
      @(negedge clk);
      chk("rr_rd_ready", rd_req_ready, (c % 2) == 0);
      chk("rr_wr_ready", wr_req_ready, (c % 2) == 1);
      if ((c % 2) == 0) exp_q.push_back(pat(32));
      next_cycle();
    end
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    @(negedge clk);
    chk("rr_rd_count", rd_count, 4);
    chk("rr_wr_count", wr_count, 4);
    idle(4);

    // Backpressure: only RESP_DEPTH reads outstanding, then in-order drain.
    rd_resp_ready = 1'b0;
    nxt = 0;
    for (int c = 0; c < 8; c++) begin
      rd_req_valid = 1'b1; rd_req_addr = waddr_t'(nxt);
      @(negedge clk);
      e_rdy = (c < 3);
      chk("bp_rd_ready", rd_req_ready, e_rdy);
      if (c >= 2) chk("bp_resp_valid", rd_resp_valid, 1);
      if (e_rdy) begin
        exp_q.push_back(pat(nxt));
        nxt++;
      end
      next_cycle();
    end
    rd_resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_no_credit", rd_req_ready, 0);
    next_cycle();
    @(negedge clk);
    chk("bp_resume", rd_req_ready, 1);
    exp_q.push_back(pat(nxt));
    next_cycle();
    idle(6);

    // Full rate: 16 back-to-back accepts and 16 consecutive responses.
    for (int c = 0; c < 19; c++) begin
      rd_req_valid = (c < 16);
      rd_req_addr  = waddr_t'(48 + c);
      @(negedge clk);
      if (c < 16) begin
        chk("fr_rd_ready", rd_req_ready, 1);
        exp_q.push_back(pat(48 + c));
      end
      chk("fr_resp_valid", rd_resp_valid, (c >= 2) && (c < 18));
      next_cycle();
    end
    idle(2);

    // Partial-strobe write only touches bytes 0-3.
    wr_req_valid = 1'b1; wr_req_addr = waddr_t'(28'h5);
    wr_req_data  = 128'hFFEEDDCC_BBAA9988_77665544_11223344;
    wr_req_strb  = 16'h000F;
    @(negedge clk);
    chk("strb_wr_ready", wr_req_ready, 1);
    next_cycle();
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b1; rd_req_addr = waddr_t'(28'h5);
    @(negedge clk);
    chk("strb_rd_ready", rd_req_ready, 1);
    exp_q.push_back(128'hA5A5A505_A5A5A505_A5A5A505_11223344);
    next_cycle();
    idle(4);

    // Reset one cycle after a read grant: response discarded.
    rd_req_valid = 1'b1; rd_req_addr = waddr_t'(28'h7);
    @(negedge clk);
    chk("mr_rd_ready", rd_req_ready, 1);
    next_cycle();
    rd_req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mr_resp_in_rst", rd_resp_valid, 0);
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mr_no_resp", rd_resp_valid, 0);
      if (c == 0) begin
        chk("mr_rd_count", rd_count, 0);
        chk("mr_wr_count", wr_count, 0);
      end
      next_cycle();
    end
    rd_req_valid = 1'b1; rd_req_addr = waddr_t'(28'h8);
    wr_req_valid = 1'b1; wr_req_addr = waddr_t'(28'h9);
    wr_req_strb  = 16'h0000;
    @(negedge clk);
    chk("mr_tie_rd", rd_req_ready, 1);
    chk("mr_tie_wr", wr_req_ready, 0);
    exp_q.push_back(pat(8));
    next_cycle();
    idle(5);

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_dma_ram_arbiter

`default_nettype wire

// File: doc/dma_ram_arbiter.md
Name: dma_ram_arbiter

Overview:
- Shares one single-port, 1-cycle-read-latency RAM port between two requesters: the MM2S read engine and the S2MM write engine of the DMA loopback.
- Sits between the DMA controller datapath and the memory port (mem_ren/mem_wen/mem_addr/mem_wdata/mem_strb/mem_rdata), which the bench services byte-wise.
- Round-robin arbitration with valid/ready handshakes on both request channels.
- Buffered read responses with credit-based backpressure, plus transfer counters for the controller status registers.

Parameters:
- AXI_WIDTH, 128, data word width in bits; multiple of 8.
- AXI_ADDR_WIDTH, 32, byte address width.
- RESP_DEPTH, 3, read-response FIFO depth; must be ≥2; 3 sustains one read per cycle.
- LSB (localparam), $clog2(AXI_WIDTH)-3, word-address shift; word address width is AXI_ADDR_WIDTH-LSB.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rd_req_valid  in  1  MM2S read request valid.
- rd_req_ready  out  1  read request accepted this cycle.
- rd_req_addr  in  AXI_ADDR_WIDTH-LSB  read word address.
- rd_resp_valid  out  1  read data valid (FIFO head).
- rd_resp_ready  in  1  MM2S accepts read data.
- rd_resp_data  out  AXI_WIDTH  read data.
- wr_req_valid  in  1  S2MM write request valid.
- wr_req_ready  out  1  write accepted and committed this cycle.
- wr_req_addr  in  AXI_ADDR_WIDTH-LSB  write word address.
- wr_req_data  in  AXI_WIDTH  write data.
- wr_req_strb  in  AXI_WIDTH/8  byte enables.
- mem_ren  out  1  RAM read enable.
- mem_wen  out  1  RAM write enable.
- mem_addr  out  AXI_ADDR_WIDTH-LSB  RAM word address.
- mem_wdata  out  AXI_WIDTH  RAM write data.
- mem_strb  out  AXI_WIDTH/8  RAM byte strobes.
- mem_rdata  in  AXI_WIDTH  RAM read data, valid the cycle after mem_ren.
- rd_count  out  32  accepted reads since reset.
- wr_count  out  32  accepted writes since reset.

Behaviour:
- Reset (rst high at posedge):
  - FIFO flushed and inflight cleared.
  - last_grant set to WR, so a read wins the first tie.
  - Counters cleared to 0.
  - While rst is high, grants are forced to 0: mem_ren=mem_wen=0, rd_req_ready=wr_req_ready=0, rd_resp_valid=0.
- Eligibility:
  - rd_elig = rd_req_valid && (fifo_count + inflight < RESP_DEPTH). Pop is not credited, so there is no combinational path from rd_resp_ready to rd_req_ready.
  - wr_elig = wr_req_valid.
- Grant (combinational):
  - If only one requester is eligible, it is granted.
  - If both are eligible, the one not in last_grant is granted.
  - last_grant updates only on a grant.
  - Ready may depend on valid; a requester must not drop valid before ready.
- Memory outputs:
  - mem_ren = grant_rd and mem_wen = grant_wr; never both high.
  - mem_addr is muxed by grant.
  - mem_wdata/mem_strb carry the write-channel values whenever grant_wr is set; don't-care otherwise.
- Write: commits at the posedge of its grant cycle. A read granted in a later cycle sees the new data.
- Read pipeline:
  - Grant in cycle N sets inflight=1 for cycle N+1.
  - mem_rdata is captured into the FIFO at the end of N+1.
  - rd_resp_valid rises in N+2; grant-to-resp latency is 2 cycles.
- Response FIFO:
  - Registered outputs; in-order delivery.
  - Pop on rd_resp_valid && rd_resp_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow is impossible by the credit rule; an overflow is an assertion failure.
- Counters:
  - Increment on grant; wrap from 2^32-1 to 0.
- Reset mid-operation: in-flight and buffered reads are discarded with no response; requesters reissue.
- Ordering: no ordering guarantee between the read and write channels beyond the round-robin grant order.

Decomposition:
- Package dma_ram_pkg holds:
  - Constants AXI_WIDTH, AXI_ADDR_WIDTH, LSB.
  - Typedefs word_t, waddr_t, strb_t.
  - enum grant_e {GR_RD, GR_WR}.
- Submodule dma_resp_fifo: a synchronous FIFO with DEPTH, push/pop, count, and registered head data/valid, reset by rst.

Test Plan:
- Reset: hold rst for 2 cycles with both valids high -> mem_ren=mem_wen=0, both readies 0, rd_resp_valid=0, rd_count=wr_count=0.
- Write then read:
  - Stimulus: write addr 0x10, data 0x...DEADBEEF, strb 0xFFFF in cycle 0; read addr 0x10 from cycle 1.
  - Expected: write accepted in cycle 0, read accepted in cycle 1, rd_resp_valid in cycle 3 with data 0x...DEADBEEF.
- Contention: both valids held for 8 cycles after reset -> grants RD,WR,RD,WR,...; rd_count=4, wr_count=4; mem_ren and mem_wen never both high.
- Backpressure:
  - Stimulus: rd_resp_ready=0 with continuous reads to addrs 0,1,2,3,...
  - Expected: exactly 3 reads accepted, then rd_req_ready=0.
  - On raising rd_resp_ready, data for addrs 0,1,2 emerge in order and reads resume.
- Full rate and strobes:
  - Stimulus: reads only, rd_resp_ready=1, 16 back-to-back reads.
  - Expected: 16 accepts in 16 consecutive cycles and 16 responses in consecutive cycles.
  - A write with strb 0x000F changes only bytes 0-3 of the target word.
- Reset mid-stream:
  - Stimulus: assert rst one cycle after a read grant.
  - Expected: no rd_resp_valid from that read after reset; counters read 0; next tie grants RD.
